// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - multiplexed common-anode seven-segment scan driver
module seg7_scan_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 25000000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blink_in,
  input  logic                    hex_mode,
  input  logic                    lz_blank,
  output logic                    ca,
  output logic                    cb,
  output logic                    cc,
  output logic                    cd,
  output logic                    ce,
  output logic                    cf,
  output logic                    cg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
  localparam logic [BW-1:0] BLK_LAST = BW'(BLINK_DIV - 1);

  logic [CW-1:0]           cnt;
  logic [IW-1:0]           idx;
  logic [BW-1:0]           bcnt;
  logic                    ph;
  logic [4*NUM_DIGITS-1:0] sh_digits;
  logic [NUM_DIGITS-1:0]   sh_dp;
  logic [NUM_DIGITS-1:0]   sh_blink;

  logic [3:0]            nib;
  logic                  sel_dp;
  logic                  sel_blink;
  logic                  lz_hit;
  logic                  all_zero;
  logic                  blank;
  logic [NUM_DIGITS-1:0] an_d;
  logic [6:0]            seg_d;
  logic [6:0]            seg_q;
  logic                  dp_d;

  function automatic logic [6:0] seg_pattern(input logic [3:0] v);
    case (v)
      4'h0: seg_pattern = 7'b0000001;
      4'h1: seg_pattern = 7'b1001111;
      4'h2: seg_pattern = 7'b0010010;
      4'h3: seg_pattern = 7'b0000110;
      4'h4: seg_pattern = 7'b1001100;
      4'h5: seg_pattern = 7'b0100100;
      4'h6: seg_pattern = 7'b0100000;
      4'h7: seg_pattern = 7'b0001111;
      4'h8: seg_pattern = 7'b0000000;
      4'h9: seg_pattern = 7'b0000100;
      4'hA: seg_pattern = 7'b0001000;
      4'hB: seg_pattern = 7'b1100000;
      4'hC: seg_pattern = 7'b0110001;
      4'hD: seg_pattern = 7'b1000010;
      4'hE: seg_pattern = 7'b0110000;
      default: seg_pattern = 7'b0111000;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
      idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcnt <= '0;
      ph   <= 1'b0;
    end else if (bcnt == BLK_LAST) begin
      bcnt <= '0;
      ph   <= ~ph;
    end else begin
      bcnt <= bcnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_digits <= '0;
      sh_dp     <= '0;
      sh_blink  <= '0;
    end else if (load) begin
      sh_digits <= digits_in;
      sh_dp     <= dp_in;
      sh_blink  <= blink_in;
    end
  end

  // Scan from the top digit down so all_zero covers digits idx..NUM_DIGITS-1 when idx matches.
  always_comb begin
    nib       = 4'h0;
    sel_dp    = 1'b0;
    sel_blink = 1'b0;
    lz_hit    = 1'b0;
    all_zero  = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      if (i > 0) all_zero = all_zero & (sh_digits[4*i +: 4] == 4'h0);
      if (IW'(i) == idx) begin
        nib       = sh_digits[4*i +: 4];
        sel_dp    = sh_dp[i];
        sel_blink = sh_blink[i];
        lz_hit    = (i > 0) && all_zero;
      end
    end

    blank = (cnt == '0) || (sel_blink && ph) || (lz_blank && lz_hit);
    an_d  = '1;
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    if (!blank) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (IW'(i) == idx) an_d[i] = 1'b0;
      end
      dp_d = ~sel_dp;
      if (hex_mode || nib < 4'd10) seg_d = seg_pattern(nib);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an    <= '1;
      seg_q <= 7'h7F;
      dp    <= 1'b1;
    end else begin
      an    <= an_d;
      seg_q <= seg_d;
      dp    <= dp_d;
    end
  end

  assign {ca, cb, cc, cd, ce, cf, cg} = seg_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - table, hand-sequence and random checks of seg7_scan_driver
module tb_seg7_scan_driver;
  localparam int N = 4;
  localparam int R = 4;
  localparam int B = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           load;
  logic [4*N-1:0] digits_in;
  logic [N-1:0]   dp_in;
  logic [N-1:0]   blink_in;
  logic           hex_mode;
  logic           lz_blank;
  logic           ca, cb, cc, cd, ce, cf, cg, dp;
  logic [N-1:0]   an;

  always #5 clk = ~clk;

  seg7_scan_driver #(.NUM_DIGITS(N), .REFRESH_DIV(R), .BLINK_DIV(B)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .digits_in(digits_in), .dp_in(dp_in),
    .blink_in(blink_in), .hex_mode(hex_mode), .lz_blank(lz_blank),
    .ca(ca), .cb(cb), .cc(cc), .cd(cd), .ce(ce), .cf(cf), .cg(cg), .dp(dp), .an(an)
  );

  localparam logic [6:0] SEG_TAB [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000, 7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  typedef struct packed {
    logic [15:0] dg;
    logic [3:0]  dpv;
    logic [3:0]  bl;
    logic        hx;
    logic        lz;
    logic [47:0] frame;
  } vec_t;

  vec_t vt [8];

  int vectors = 0;
  int miscompares = 0;
  int n_edges = 0;
  logic [4*N-1:0] m_digits;
  logic [N-1:0]   m_dp;
  logic [N-1:0]   m_blink;
  logic [4*N-1:0] rdg;
  logic           rhx, rlz;

  // Expected {an, segs, dp} for the edge following n_edges edges since release.
  function automatic logic [11:0] model_out(int n, logic hx, logic lz);
    int slot;
    int d;
    int val;
    logic ph;
    logic [4*N-1:0] upper;
    logic [N-1:0] an_e;
    logic [6:0] seg_e;
    slot  = n % R;
    d     = (n / R) % N;
    ph    = ((n / B) % 2) == 1;
    upper = m_digits >> (4 * d);
    val   = int'(upper[3:0]);
    if (slot == 0) return 12'hFFF;
    if (m_blink[d] && ph) return 12'hFFF;
    if (lz && d != 0 && upper == '0) return 12'hFFF;
    an_e    = '1;
    an_e[d] = 1'b0;
    seg_e   = (hx || val < 10) ? SEG_TAB[val] : 7'h7F;
    return {an_e, seg_e, ~m_dp[d]};
  endfunction

  function automatic logic [11:0] pins();
    return {an, ca, cb, cc, cd, ce, cf, cg, dp};
  endfunction

  task automatic check(string name, logic [11:0] act, logic [11:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s edge %0d: got an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b",
               name, n_edges, act[11:8], act[7:1], act[0], req[11:8], req[7:1], req[0]);
    end
  endtask

  task automatic step(logic ld, logic [15:0] dg, logic [3:0] dpv, logic [3:0] bl, logic hx, logic lz);
    logic [11:0] e_out;
    load = ld; digits_in = dg; dp_in = dpv; blink_in = bl; hex_mode = hx; lz_blank = lz;
    e_out = model_out(n_edges, hx, lz);
    @(posedge clk);
    if (ld) begin
      m_digits = dg; m_dp = dpv; m_blink = bl;
    end
    n_edges++;
    #1 check("scan", pins(), e_out);
  endtask

  task automatic do_reset(int cycles);
    rst_n = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      load = 1'($urandom_range(0, 1)); digits_in = 16'($urandom);
      dp_in = 4'($urandom); blink_in = 4'($urandom);
      hex_mode = 1'($urandom_range(0, 1)); lz_blank = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1 check("reset", pins(), 12'hFFF);
    end
    rst_n = 1'b1;
    n_edges = 0; m_digits = '0; m_dp = '0; m_blink = '0;
  endtask

  initial begin
    rst_n = 1'b0; load = 1'b0; digits_in = '0; dp_in = '0; blink_in = '0;
    hex_mode = 1'b0; lz_blank = 1'b0;

    vt[0] = '{16'h1234, 4'b0001, 4'b0000, 1'b0, 1'b0,
              {4'b0111,7'b1001111,1'b1, 4'b1011,7'b0010010,1'b1, 4'b1101,7'b0000110,1'b1, 4'b1110,7'b1001100,1'b0}};
    vt[1] = '{16'hABCD, 4'b1010, 4'b0000, 1'b1, 1'b0,
              {4'b0111,7'b0001000,1'b0, 4'b1011,7'b1100000,1'b1, 4'b1101,7'b0110001,1'b0, 4'b1110,7'b1000010,1'b1}};
    vt[2] = '{16'hABCD, 4'b1010, 4'b0000, 1'b0, 1'b0,
              {4'b0111,7'h7F,1'b0, 4'b1011,7'h7F,1'b1, 4'b1101,7'h7F,1'b0, 4'b1110,7'h7F,1'b1}};
    vt[3] = '{16'h0040, 4'b0000, 4'b0000, 1'b0, 1'b1,
              {12'hFFF, 12'hFFF, 4'b1101,7'b1001100,1'b1, 4'b1110,7'b0000001,1'b1}};
    vt[4] = '{16'h0000, 4'b1111, 4'b0000, 1'b0, 1'b1,
              {12'hFFF, 12'hFFF, 12'hFFF, 4'b1110,7'b0000001,1'b0}};
    vt[5] = '{16'h1000, 4'b0000, 4'b0000, 1'b0, 1'b1,
              {4'b0111,7'b1001111,1'b1, 4'b1011,7'b0000001,1'b1, 4'b1101,7'b0000001,1'b1, 4'b1110,7'b0000001,1'b1}};
    vt[6] = '{16'h5678, 4'b0001, 4'b1100, 1'b0, 1'b0,
              {12'hFFF, 12'hFFF, 4'b1101,7'b0001111,1'b1, 4'b1110,7'b0000000,1'b0}};
    vt[7] = '{16'h5678, 4'b0000, 4'b0010, 1'b0, 1'b0,
              {4'b0111,7'b0100100,1'b1, 4'b1011,7'b0100000,1'b1, 4'b1101,7'b0001111,1'b1, 4'b1110,7'b0000000,1'b1}};

    // One frame per table row: load on the first edge after release, spot-check each digit slot.
    for (int v = 0; v < 8; v++) begin
      do_reset(2);
      step(1'b1, vt[v].dg, vt[v].dpv, vt[v].bl, vt[v].hx, vt[v].lz);
      for (int e = 2; e <= N * R; e++) begin
        step(1'b0, 16'($urandom), 4'($urandom), 4'($urandom), vt[v].hx, vt[v].lz);
        if ((e - 2) % R == 0) check("table", pins(), vt[v].frame[12*((e-2)/R) +: 12]);
      end
    end

    // Blink across several half-periods with a decimal point on digit 0.
    do_reset(1);
    step(1'b1, 16'h1234, 4'b0001, 4'b0010, 1'b0, 1'b0);
    for (int e = 0; e < 3 * N * R; e++) step(1'b0, 16'h0, 4'h0, 4'h0, 1'b0, 1'b0);

    // Load while digit 2 is lit, then asynchronous reset in the middle of a slot.
    do_reset(1);
    step(1'b1, 16'h1234, 4'b0000, 4'b0000, 1'b0, 1'b0);
    for (int e = 2; e <= 10; e++) step(1'b0, 16'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    check("digit2_before", pins(), {4'b1011, 7'b0010010, 1'b1});
    step(1'b1, 16'h5678, 4'b0000, 4'b0000, 1'b0, 1'b0);
    step(1'b0, 16'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    check("midload", pins(), {4'b1011, 7'b0100000, 1'b1});
    #2 rst_n = 1'b0;
    #1 check("async_reset", pins(), 12'hFFF);
    do_reset(2);
    for (int e = 0; e < N * R; e++) step(1'b0, 16'h0, 4'h0, 4'h0, 1'b0, 1'b0);

    // Randomized traffic against the model, biased toward leading-zero runs.
    do_reset(3);
    rhx = 1'b0; rlz = 1'b1;
    for (int s = 0; s < 800; s++) begin
      rdg = 16'($urandom);
      for (int k = N - 1; k >= 1; k--) begin
        if ($urandom_range(0, 1) == 1) rdg[4*k +: 4] = 4'h0;
        else break;
      end
      if ($urandom_range(0, 15) == 0) rhx = ~rhx;
      if ($urandom_range(0, 15) == 0) rlz = ~rlz;
      step(1'($urandom_range(0, 7) == 0), rdg, 4'($urandom), 4'($urandom), rhx, rlz);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Multiplexed N-digit seven-segment display driver for the board's common-anode display. It latches a packed digit word on a load strobe and time-multiplexes the digits onto shared active-low segment lines, one anode at a time, with one blanked cycle between digits. Per-digit decimal points and blinking, hex/decimal mode, and leading-zero blanking are supported. It sits between game logic (score/timer) and the display pins, replacing per-digit combinational decoding.

## Interface
- NUM_DIGITS, 4, number of digits scanned (1..8)
- REFRESH_DIV, 100000, clock cycles each digit slot lasts (≥2)
- BLINK_DIV, 25000000, clock cycles per blink half-period (≥1)

- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- load  in  1  capture strobe for digits_in/dp_in/blink_in
- digits_in  in  4*NUM_DIGITS  packed nibbles; [3:0] = digit 0 (rightmost)
- dp_in  in  NUM_DIGITS  decimal point enable per digit (1 = lit)
- blink_in  in  NUM_DIGITS  blink enable per digit
- hex_mode  in  1  1 = show 10..15 as A,b,C,d,E,F; 0 = blank them
- lz_blank  in  1  1 = blank leading zeros
- ca,cb,cc,cd,ce,cf,cg  out  1 each  segments a..g, active-low, registered
- dp  out  1  decimal point, active-low, registered
- an  out  NUM_DIGITS  anodes, active-low, one-hot-low or all high, registered

## Operation
- Shadow registers (digits, dp, blink) load on any edge with load=1; otherwise hold. Display reads only shadows.
- Refresh counter cnt: 0..REFRESH_DIV-1, wraps. On the edge where cnt=REFRESH_DIV-1, scan index idx advances; NUM_DIGITS-1 wraps to 0.
- Blink counter: 0..BLINK_DIV-1; at terminal count blink phase ph toggles.
- Output registers update every edge from current cnt, idx, ph, shadows, hex_mode, lz_blank:
  - cnt=0: anti-ghost gap; an all 1, segments all 1, dp=1.
  - Digit idx blanked (an all 1, segments 1, dp 1) if: (blink[idx] and ph=1) or (lz_blank and idx≠0 and shadow digits idx..NUM_DIGITS-1 all zero).
  - Otherwise an[idx]=0, others 1; dp = ~dp[idx]; segments from nibble.
- Segment patterns {a..g}, active-low: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
- hex_mode=0 and nibble 10..15: segments all 1 while an[idx] stays 0 (digit slot active, dark). dp still follows dp[idx].
- Digit 0 is never leading-zero blanked (value 0 shows "0").

## Timing
- Reset (async assert, sync release): cnt=0, idx=0, blink counter=0, ph=0, shadows=0, an all 1, ca..cg=1, dp=1.
- First cycle after release: cnt=0, so outputs remain off. Digit 0 is driven from the second edge after release, and stays on through cnt=REFRESH_DIV-1.
- Each digit is lit REFRESH_DIV-1 cycles, then dark 1 cycle. Full frame = NUM_DIGITS*REFRESH_DIV cycles.
- load to output: a shadow written at edge t appears on pins at edge t+1 if that digit is in an active slot. No tearing within a slot beyond that single change.
- load coinciding with an idx advance: both take effect; the new idx uses the new shadows from the next edge.
- Mode inputs (hex_mode, lz_blank) are unlatched: 1-cycle latency to pins.
- Reset mid-frame: outputs go dark immediately (asynchronous); shadows are cleared.

## Test plan
- Reset: hold rst_n=0 with random inputs → an=all 1, ca..cg=1, dp=1. Release → first lit digit is digit 0 after 2 edges.
- Scan order (NUM_DIGITS=4, REFRESH_DIV=4): load 0x1234 → an sequence 1110,1101,1011,0111, each 3 cycles, separated by 1-cycle 1111. Segments show 4,3,2,1.
- Hex mode: load 0xABCD, hex_mode=1 → d,C,b,A patterns. hex_mode=0 → anodes still cycle but segments all 1.
- Leading zeros: lz_blank=1, load 0x0040 → digits 3,2 dark, digit 1 shows 4, digit 0 shows 0. Load 0x0000 → only digit 0 lit ("0"). Load 0x1000 → digits 2,1,0 show 0.
- Blink/dp (BLINK_DIV=8): blink_in=0010, dp_in=0001 → digit 1 dark while ph=1 and lit while ph=0, with ph toggling every 8 cycles. dp=0 only in digit 0's slot.
- Load mid-slot: load 0x5678 while digit 2 is active → its segments change to 6 exactly one edge later. Assert rst_n mid-slot → outputs off in the same cycle.
